// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states and
// the divide-by-zero result fill.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_MUL = 4'b0011;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_OR  = 4'b0111;
  localparam logic [3:0] OP_NEG = 4'b1000;
  localparam logic [3:0] OP_NOT = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_SHL = 4'b1100;
  localparam logic [3:0] OP_SHR = 4'b1101;
  localparam logic [3:0] OP_ROL = 4'b1110;
  localparam logic [3:0] OP_ROR = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Divide by zero returns an all-ones quotient; the remainder is the dividend.
  localparam logic DIV0_LO_FILL = 1'b1;

endpackage

// File: rtl/seq_divider.sv
// Iterative signed restoring divider: one quotient bit per cycle on |a|/|b|,
// W steps after start; done_o marks the final step with signed results valid.
module seq_divider #(
  parameter int W  = 32,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start_i,
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic [CW-1:0] count_o,
  output logic          done_o,
  output logic [W-1:0]  quo_o,
  output logic [W-1:0]  rem_o
);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dvs_q;
  logic          qneg_q;
  logic          rneg_q;

  logic [W:0]    trial;
  logic [W-1:0]  rem_n;
  logic [W-1:0]  quo_n;

  // quo_q shifts the dividend out at the top while quotient bits enter at the bottom.
  always_comb begin
    trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};
    if (!trial[W]) begin
      rem_n = trial[W-1:0];
      quo_n = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_n = {rem_q[W-2:0], quo_q[W-1]};
      quo_n = {quo_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(W - 1);
      rem_q  <= '0;
      quo_q  <= a_i[W-1] ? -a_i : a_i;
      dvs_q  <= b_i[W-1] ? -b_i : b_i;
      qneg_q <= a_i[W-1] ^ b_i[W-1];
      rneg_q <= a_i[W-1];
    end else if (busy_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end
    end
  end

  // Magnitude of -2^(W-1) wraps to itself, so the overflow case falls out naturally.
  assign quo_o   = qneg_q ? -quo_n : quo_n;
  assign rem_o   = rneg_q ? -rem_n : rem_n;
  assign done_o  = busy_q && (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/MUL, iterative signed DIV.
// One op per start/ready handshake, results in {z_hi,z_lo} with a done pulse.
module alu_mc
  import alu_pkg::*;
#(
  parameter int W   = 32,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  output logic         ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] z_lo,
  output logic [W-1:0] z_hi,
  output logic         done,
  output logic         div_by_zero
);

  state_e         state_q, state_d;
  logic [W-1:0]   z_lo_q, z_lo_d;
  logic [W-1:0]   z_hi_q, z_hi_d;
  logic [W-1:0]   a_q, a_d;
  logic           done_q, done_d;
  logic           dz_q, dz_d;

  logic           div_start;
  logic [SHW-1:0] div_count;
  logic           div_done;
  logic [W-1:0]   div_quo;
  logic [W-1:0]   div_rem;

  logic [SHW-1:0] sh;
  logic [2*W-1:0] prod;
  logic [W-1:0]   alu_lo;
  logic [W-1:0]   alu_hi;

  seq_divider #(
    .W  (W),
    .CW (SHW)
  ) u_div (
    .clk     (clk),
    .clear   (clear),
    .start_i (div_start),
    .a_i     (a),
    .b_i     (b),
    .count_o (div_count),
    .done_o  (div_done),
    .quo_o   (div_quo),
    .rem_o   (div_rem)
  );

  assign sh   = b[SHW-1:0];
  assign prod = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};

  // Single-cycle results; unlisted opcodes (and DIV) leave both halves unchanged.
  always_comb begin
    alu_lo = z_lo_q;
    alu_hi = z_hi_q;
    case (op)
      OP_ADD: alu_lo = a + b;
      OP_SUB: alu_lo = a - b;
      OP_MUL: {alu_hi, alu_lo} = prod;
      OP_AND: alu_lo = a & b;
      OP_OR:  alu_lo = a | b;
      OP_NOT: alu_lo = ~b;
      OP_NEG: alu_lo = -b;
      OP_SRA: alu_lo = $signed(a) >>> sh;
      OP_SHL: alu_lo = a << sh;
      OP_SHR: alu_lo = a >> sh;
      OP_ROL: alu_lo = (a << sh) | (a >> (W - int'(sh)));
      OP_ROR: alu_lo = (a >> sh) | (a << (W - int'(sh)));
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    z_lo_d    = z_lo_q;
    z_hi_d    = z_hi_q;
    a_d       = a_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    div_start = 1'b0;
    ready     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          a_d  = a;
          dz_d = 1'b0;
          if (op == OP_DIV) begin
            if (b == '0) begin
              dz_d    = 1'b1;
              state_d = ST_FIN;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end else begin
            z_lo_d = alu_lo;
            z_hi_d = alu_hi;
            done_d = 1'b1;
          end
        end
      end
      ST_DIV: begin
        // The last quotient bit is produced in FIN together with the sign fix-up.
        if (div_count == SHW'(1)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (dz_q) begin
          z_lo_d = {W{DIV0_LO_FILL}};
          z_hi_d = a_q;
        end else if (div_done) begin
          z_lo_d = div_quo;
          z_hi_d = div_rem;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= ST_IDLE;
      z_lo_q  <= '0;
      z_hi_q  <= '0;
      a_q     <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      z_lo_q  <= z_lo_d;
      z_hi_q  <= z_hi_d;
      a_q     <= a_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign z_lo        = z_lo_q;
  assign z_hi        = z_hi_q;
  assign done        = done_q;
  assign div_by_zero = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: table-driven vectors through a result scoreboard, plus
// hand sequences for DIV latency, divide-by-zero, clear abort and back-to-back ops.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] T_ADD = 4'b0001;
  localparam logic [3:0] T_SUB = 4'b0010;
  localparam logic [3:0] T_MUL = 4'b0011;
  localparam logic [3:0] T_DIV = 4'b0101;
  localparam logic [3:0] T_AND = 4'b0110;
  localparam logic [3:0] T_OR  = 4'b0111;
  localparam logic [3:0] T_NEG = 4'b1000;
  localparam logic [3:0] T_NOT = 4'b1010;
  localparam logic [3:0] T_SRA = 4'b1011;
  localparam logic [3:0] T_SHL = 4'b1100;
  localparam logic [3:0] T_SHR = 4'b1101;
  localparam logic [3:0] T_ROL = 4'b1110;
  localparam logic [3:0] T_ROR = 4'b1111;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dz;
  } exp_t;

  logic         clk;
  logic         clear;
  logic         start;
  logic         ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] z_lo;
  logic [W-1:0] z_hi;
  logic         done;
  logic         div_by_zero;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vt[26];

  alu_mc #(.W(W)) dut (
    .clk         (clk),
    .clear       (clear),
    .start       (start),
    .ready       (ready),
    .op          (op),
    .a           (a),
    .b           (b),
    .z_lo        (z_lo),
    .z_hi        (z_hi),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] lo, input logic [W-1:0] hi, input logic dz);
    exp_t e;
    e.lo = lo;
    e.hi = hi;
    e.dz = dz;
    sb.push_back(e);
  endtask

  // Scoreboard monitor: every done pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done (z_lo=%h)", z_lo);
        end else begin
          e = sb.pop_front();
          chk("sb_z_lo", z_lo, e.lo);
          chk("sb_z_hi", z_hi, e.hi);
          chk("sb_div_by_zero", W'(div_by_zero), W'(e.dz));
        end
      end
    end
  end

  initial begin
    int n;
    int lat;
    int rlow;

    vt[0]  = '{T_ADD, 32'd7,          32'hFFFF_FFFD, 32'd4,          32'd0};
    vt[1]  = '{T_SUB, 32'd5,          32'd8,         32'hFFFF_FFFD,  32'd0};
    vt[2]  = '{T_MUL, 32'h0001_0000,  32'h0001_0000, 32'd0,          32'd1};
    vt[3]  = '{T_MUL, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFA,  32'hFFFF_FFFF};
    vt[4]  = '{T_AND, 32'hF0F0_1234,  32'h0FF0_FF00, 32'h00F0_1200,  32'hFFFF_FFFF};
    vt[5]  = '{T_OR,  32'hF000_0000,  32'h0000_000F, 32'hF000_000F,  32'hFFFF_FFFF};
    vt[6]  = '{T_NOT, 32'd0,          32'h0000_FFFF, 32'hFFFF_0000,  32'hFFFF_FFFF};
    vt[7]  = '{T_NEG, 32'd0,          32'd5,         32'hFFFF_FFFB,  32'hFFFF_FFFF};
    vt[8]  = '{T_SRA, 32'h8000_0000,  32'd4,         32'hF800_0000,  32'hFFFF_FFFF};
    vt[9]  = '{T_SHL, 32'd1,          32'd31,        32'h8000_0000,  32'hFFFF_FFFF};
    vt[10] = '{T_SHR, 32'h8000_0000,  32'd4,         32'h0800_0000,  32'hFFFF_FFFF};
    vt[11] = '{T_ROL, 32'h8000_0001,  32'd1,         32'h0000_0003,  32'hFFFF_FFFF};
    vt[12] = '{T_ROR, 32'h0000_0001,  32'd33,        32'h8000_0000,  32'hFFFF_FFFF};
    vt[13] = '{T_ROL, 32'h1234_5678,  32'd32,        32'h1234_5678,  32'hFFFF_FFFF};
    vt[14] = '{4'b0000, 32'hDEAD_BEEF, 32'd9,        32'h1234_5678,  32'hFFFF_FFFF};
    vt[15] = '{4'b1001, 32'h1111_1111, 32'd2,        32'h1234_5678,  32'hFFFF_FFFF};
    vt[16] = '{T_MUL, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h0000_0001,  32'h3FFF_FFFF};
    vt[17] = '{T_SUB, 32'h8000_0000,  32'd1,         32'h7FFF_FFFF,  32'h3FFF_FFFF};
    vt[18] = '{T_DIV, 32'd100,        32'd7,         32'd14,         32'd2};
    vt[19] = '{T_DIV, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2,  32'hFFFF_FFFE};
    vt[20] = '{T_DIV, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2,  32'd2};
    vt[21] = '{T_DIV, 32'hFFFF_FF9C,  32'hFFFF_FFF9, 32'd14,         32'hFFFF_FFFE};
    vt[22] = '{T_DIV, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  32'd0};
    vt[23] = '{T_DIV, 32'd3,          32'd10,        32'd0,          32'd3};
    vt[24] = '{T_ADD, 32'h7FFF_FFFF,  32'd1,         32'h8000_0000,  32'd3};
    vt[25] = '{T_SHR, 32'hFFFF_FFFF,  32'd32,        32'hFFFF_FFFF,  32'd3};

    clear = 1'b1;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    clear = 1'b0;

    chk("reset_ready", W'(ready), W'(1));
    chk("reset_done", W'(done), W'(0));
    chk("reset_dz", W'(div_by_zero), W'(0));
    chk("reset_z_lo", z_lo, '0);
    chk("reset_z_hi", z_hi, '0);

    // Table: each op launched as soon as ready allows.
    for (int i = 0; i < 26; i++) begin
      n = 0;
      while (!ready && n < 100) begin
        tick();
        n++;
      end
      chk("table_ready_wait", W'(n < 100), W'(1));
      op    = vt[i].op;
      a     = vt[i].a;
      b     = vt[i].b;
      start = 1'b1;
      push(vt[i].lo, vt[i].hi, 1'b0);
      tick();
      start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("table_drain", W'(sb.size()), '0);

    // DIV -7/2: latency W+1, ready low W cycles, start while busy ignored.
    op = T_DIV; a = 32'hFFFF_FFF9; b = 32'd2; start = 1'b1;
    push(32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    tick();
    start = 1'b0;
    lat = 1;
    rlow = 0;
    while (!done && lat < 200) begin
      if (!ready) rlow++;
      if (lat == 3) begin
        op = T_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    chk("div_latency", W'(lat), W'(W + 1));
    chk("div_ready_low_cycles", W'(rlow), W'(W));
    chk("div_ready_at_done", W'(ready), W'(1));

    // Divide by zero: 2-cycle latency, sticky flag cleared by next accepted start.
    op = T_DIV; a = 32'd5; b = 32'd0; start = 1'b1;
    push(32'hFFFF_FFFF, 32'd5, 1'b1);
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    chk("div0_latency", W'(lat), W'(2));
    repeat (3) tick();
    chk("div0_sticky", W'(div_by_zero), W'(1));
    op = T_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    push(32'd2, 32'd5, 1'b0);
    tick();
    start = 1'b0;
    chk("div0_cleared_on_start", W'(div_by_zero), W'(0));
    tick();

    // clear during DIV cycle 10 aborts without done and resets every output.
    op = T_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (lat < 10) begin
      tick();
      lat++;
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("abort_ready", W'(ready), W'(1));
    chk("abort_done", W'(done), W'(0));
    chk("abort_z_lo", z_lo, '0);
    chk("abort_z_hi", z_hi, '0);
    chk("abort_dz", W'(div_by_zero), W'(0));
    repeat (W + 4) tick();

    // clear wins over start in the same cycle.
    op = T_ADD; a = 32'd5; b = 32'd5; start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk("clear_prio_done", W'(done), W'(0));
    chk("clear_prio_z_lo", z_lo, '0);

    // Back-to-back ADDs: done every cycle.
    for (int i = 0; i < 4; i++) begin
      op = T_ADD; a = W'(i); b = 32'd10; start = 1'b1;
      push(W'(i + 10), 32'd0, 1'b0);
      tick();
      chk("b2b_done", W'(done), W'(1));
    end
    start = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("final_drain", W'(sb.size()), '0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
